// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types: request bundle, source tag and a register decode helper.
// Imported by the FIFO, the arbiter top and the testbench.
package Common;

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } WbReq;

    typedef enum logic {
        SrcPipe = 1'b0,
        SrcLong = 1'b1
    } WbSrc;

    function automatic logic [31:0] reg_bit(input logic [4:0] r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: pipeline and long-latency requests, RF write port, pending mask.
// master = requester/RF side, slave = arbiter side.
interface wb_port_arbiter_if;
    logic        p_valid;
    logic        p_ready;
    logic [4:0]  p_wreg;
    logic [31:0] p_wdata;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_wreg;
    logic [31:0] l_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic [31:0] pend_mask;

    modport master (
        output p_valid, p_wreg, p_wdata,
        output l_valid, l_wreg, l_wdata,
        input  p_ready, l_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_src,
        input  pend_mask
    );

    modport slave (
        input  p_valid, p_wreg, p_wdata,
        input  l_valid, l_wreg, l_wdata,
        output p_ready, l_ready,
        output rf_we, rf_waddr, rf_wdata, rf_src,
        output pend_mask
    );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Synchronous FIFO with full/empty flags; exposes every slot and its valid bit.
// Ports: clk, rst (async active-low), push/din, pop/dout, full, empty, entries, vld.
module wb_fifo
    import Common::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = WbReq
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 din,
    input  logic             pop,
    output T                 dout,
    output logic             full,
    output logic             empty,
    output T [DEPTH-1:0]     entries,
    output logic [DEPTH-1:0] vld
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    T [DEPTH-1:0]  mem;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Per-slot valid bits make full/empty trivial and feed the pending mask.
    assign full    = &vld;
    assign empty   = ~|vld;
    assign dout    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            // Push into a full FIFO is blocked, so a same-cycle push never hits rd_ptr.
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline first, long-latency queued with starvation override.
// Ports: clk, rst (async active-low), bus (slave modport: requests, RF write, pend_mask).
module wb_port_arbiter
    import Common::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic                  fifo_full;
    logic                  fifo_empty;
    WbReq                  head;
    WbReq [FIFO_DEPTH-1:0] ents;
    logic [FIFO_DEPTH-1:0] ents_vld;

    logic [SW-1:0] starve_cnt;
    logic          force_pop;
    logic          p_ready;
    logic          l_ready;
    logic          grant_p;
    logic          push;
    logic          pop;

    logic          wr_en;
    WbReq          wr_req;
    WbSrc          wr_src;

    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    WbSrc          rf_src;
    logic [31:0]   pend_mask;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH),
        .T    (WbReq)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .din    ({bus.l_wreg, bus.l_wdata}),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .entries(ents),
        .vld    (ents_vld)
    );

    // Readies are qualified by rst so nothing handshakes while held in reset.
    assign force_pop = !fifo_empty && (starve_cnt == STARVE_TOP);
    assign p_ready   = rst && !force_pop;
    assign l_ready   = rst && !fifo_full;
    assign grant_p   = bus.p_valid && p_ready;
    // x0 results complete the handshake but never occupy a slot.
    assign push      = bus.l_valid && l_ready && (bus.l_wreg != 5'd0);
    assign pop       = !fifo_empty && (force_pop || !bus.p_valid);

    always_comb begin
        wr_en  = 1'b0;
        wr_req = head;
        wr_src = SrcLong;
        unique case (1'b1)
            pop: begin
                wr_en = 1'b1;
            end
            grant_p: begin
                wr_en  = (bus.p_wreg != 5'd0);
                wr_req = {bus.p_wreg, bus.p_wdata};
                wr_src = SrcPipe;
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ents_vld[i]) pend_mask |= reg_bit(ents[i].wreg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_TOP) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Address/data/source hold their last value when no write is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= SrcPipe;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_req.wreg;
                rf_wdata <= wr_req.wdata;
                rf_src   <= wr_src;
            end
        end
    end

    assign bus.p_ready   = p_ready;
    assign bus.l_ready   = l_ready;
    assign bus.rf_we     = rf_we;
    assign bus.rf_waddr  = rf_waddr;
    assign bus.rf_wdata  = rf_wdata;
    assign bus.rf_src    = rf_src;
    assign bus.pend_mask = pend_mask;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-based reference model, directed + random traffic.
// Driver predicts each cycle's write into expq; a posedge monitor pops and compares.
module tb_wb_port_arbiter;
    import Common::*;

    localparam int DEPTH = 2;
    localparam int SM    = 4;

    typedef struct {
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        bit          s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    WbReq mq[$];
    int   starve = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, predict the next write.
    task automatic step(input bit pv, input logic [4:0] pw, input logic [31:0] pd,
                        input bit lv, input logic [4:0] lw, input logic [31:0] ld,
                        output bit p_acc, output bit l_acc);
        exp_t        e;
        bit          frc;
        bit          lr;
        bit          had;
        bit          popd;
        logic [31:0] pm;
        @(negedge clk);
        bus.p_valid = pv;
        bus.p_wreg  = pw;
        bus.p_wdata = pd;
        bus.l_valid = lv;
        bus.l_wreg  = lw;
        bus.l_wdata = ld;
        #1;
        e     = '{1'b0, 5'd0, 32'd0, 1'b0};
        p_acc = 1'b0;
        l_acc = 1'b0;
        if (!rst) begin
            chk("p_ready_rst", {31'd0, bus.p_ready}, 32'd0);
            chk("l_ready_rst", {31'd0, bus.l_ready}, 32'd0);
            chk("pend_rst", bus.pend_mask, 32'd0);
            mq.delete();
            starve = 0;
        end else begin
            had = mq.size() > 0;
            frc = had && (starve == SM);
            lr  = mq.size() < DEPTH;
            pm  = 32'd0;
            foreach (mq[i]) pm[mq[i].wreg] = 1'b1;
            chk("p_ready", {31'd0, bus.p_ready}, {31'd0, !frc});
            chk("l_ready", {31'd0, bus.l_ready}, {31'd0, lr});
            chk("pend_mask", bus.pend_mask, pm);
            popd = had && (frc || !pv);
            p_acc = pv && !frc;
            l_acc = lv && lr;
            if (popd) begin
                e = '{1'b1, mq[0].wreg, mq[0].wdata, 1'b1};
                void'(mq.pop_front());
            end else if (pv && pw != 5'd0) begin
                e = '{1'b1, pw, pd, 1'b0};
            end
            if (l_acc && lw != 5'd0) mq.push_back('{lw, ld});
            if (!had || popd) starve = 0;
            else if (starve < SM) starve++;
        end
        expq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
                if (e.we) begin
                    chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.a});
                    chk("rf_wdata", bus.rf_wdata, e.d);
                    chk("rf_src", {31'd0, bus.rf_src}, {31'd0, e.s});
                end
            end
        end
    end

    task automatic idle(input int n);
        bit pa, la;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, pa, la);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_we"}, {31'd0, bus.rf_we}, 32'd0);
        chk({tag, "_waddr"}, {27'd0, bus.rf_waddr}, 32'd0);
        chk({tag, "_wdata"}, bus.rf_wdata, 32'd0);
        chk({tag, "_src"}, {31'd0, bus.rf_src}, 32'd0);
        chk({tag, "_pend"}, bus.pend_mask, 32'd0);
        chk({tag, "_pready"}, {31'd0, bus.p_ready}, 32'd0);
        chk({tag, "_lready"}, {31'd0, bus.l_ready}, 32'd0);
    endtask

    initial begin
        bit          pa, la;
        bit          hp, hl;
        logic [4:0]  pw, lw;
        logic [31:0] pd, ld;
        int          pprob;

        bus.p_valid = 0; bus.p_wreg = 0; bus.p_wdata = 0;
        bus.l_valid = 0; bus.l_wreg = 0; bus.l_wdata = 0;
        #1;
        chk_zero_outputs("reset");
        idle(2);
        @(posedge clk);
        #2 rst = 1'b1;

        // single pipeline write, then idle
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, pa, la);
        idle(2);

        // single long-latency write into an empty queue
        step(0, 0, 0, 1, 5'd7, 32'h1234, pa, la);
        idle(3);

        // starvation: queued x9 under continuous pipeline traffic
        step(1, 5'd1, 32'h11, 1, 5'd9, 32'h99, pa, la);
        for (int i = 0; i < 7; i++) step(1, 5'(i + 2), 32'(i), 0, 0, 0, pa, la);
        idle(2);

        // three back-to-back long requests with a full queue under pipeline traffic
        hl = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hl = 1'b1;
            for (int g = 0; g < 20 && hl; g++) begin
                step(1, 5'd20, 32'(g), 1, 5'(10 + k), 32'(100 + k), pa, la);
                if (la) hl = 1'b0;
            end
            if (hl) chk("l_accept_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 12; i++) step(1, 5'd21, 32'(i), 0, 0, 0, pa, la);
        idle(3);

        // writes to x0 on both sources
        step(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB, pa, la);
        idle(2);

        // async reset with two queued entries and a write in flight
        step(1, 5'd2, 32'h22, 1, 5'd12, 32'hC1, pa, la);
        step(1, 5'd2, 32'h23, 1, 5'd13, 32'hC2, pa, la);
        step(1, 5'd3, 32'h33, 0, 0, 0, pa, la);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        mq.delete();
        starve = 0;
        idle(2);
        @(posedge clk);
        #2 rst = 1'b1;
        idle(3);

        // random traffic with valid held until accepted
        hp = 0; hl = 0; pw = 0; lw = 0; pd = 0; ld = 0; pprob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) pprob = $urandom_range(0, 100);
            if (!hp && $urandom_range(0, 99) < pprob) begin
                hp = 1'b1;
                pw = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pd = $urandom;
            end
            if (!hl && $urandom_range(0, 99) < 35) begin
                hl = 1'b1;
                lw = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ld = $urandom;
            end
            step(hp, pw, pd, hl, lw, ld, pa, la);
            if (pa) hp = 1'b0;
            if (la) hl = 1'b0;
        end
        idle(6);
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback path and the long-latency unit (loads returning from memory, divider). Pipeline writes have priority. Long-latency results queue in a small FIFO, and a starvation counter forces them through. The block drives the registered register-file write strobe and exports a pending-register mask for the hazard logic.

## Interface
- `FIFO_DEPTH`, default 2: long-latency queue entries; power of two, at least 2.
- `STARVE_MAX`, default 4: consecutive denied cycles after which the queue head is forced through; at least 1.

- `clk`: input, 1 bit. Clock; all state on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `p_valid`: input, 1 bit. Pipeline writeback request.
- `p_ready`: output, 1 bit. Pipeline request accepted this cycle.
- `p_wreg`: input, 5 bits. Pipeline destination register.
- `p_wdata`: input, 32 bits. Pipeline write data.
- `l_valid`: input, 1 bit. Long-latency result request.
- `l_ready`: output, 1 bit. Long-latency result accepted into the queue.
- `l_wreg`: input, 5 bits. Long-latency destination register.
- `l_wdata`: input, 32 bits. Long-latency write data.
- `rf_we`: output, 1 bit. Register-file write enable; registered.
- `rf_waddr`: output, 5 bits. Register-file write address; registered.
- `rf_wdata`: output, 32 bits. Register-file write data; registered.
- `rf_src`: output, 1 bit. Source of the current write: 0 = pipeline, 1 = long-latency; registered.
- `pend_mask`: output, 32 bits. Bit r is set while any queued long-latency entry targets register r.

## Operation
- A handshake completes on a cycle where valid and ready are both high.
- Long-latency requests enter the FIFO.
  - `l_ready` = FIFO not full.
  - A push and a pop in the same cycle are allowed, but `l_ready` does not look ahead to the pop.
- Writes to x0:
  - A pipeline request with `p_wreg`=0 completes its handshake but produces no `rf_we`.
  - A long-latency request with `l_wreg`=0 completes its handshake and is not pushed.
- Arbitration each cycle, in priority order:
  - `force` = FIFO non-empty and `starve_cnt` == `STARVE_MAX`.
  - If `force`: the queue head is popped and written, and `p_ready`=0.
  - Else if `p_valid`: the pipeline write is granted and `p_ready`=1.
  - Else if the FIFO is non-empty: the head is popped and written.
  - Else: no write.
- `p_ready` = NOT `force`. It does not depend on `p_valid`.
- `starve_cnt`:
  - Cleared on any pop and whenever the FIFO is empty.
  - Incremented, saturating at `STARVE_MAX`, on each cycle the FIFO is non-empty and the head is not popped.
- `pend_mask` is the OR of the one-hot decodes of the `wreg` fields of all valid FIFO entries. It is combinational from FIFO state and does not include a push that is in flight this cycle.
- Ordering:
  - Writes from the same source retire in arrival order.
  - Ordering between sources is not enforced here. The hazard unit stalls issue against `pend_mask`.
- While `rst` is low: `p_ready`=0, `l_ready`=0, and all state is cleared.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_src`=0, `pend_mask`=0, FIFO empty, `starve_cnt`=0.
- Latency:
  - Pipeline: `rf_we` is high on the cycle after the handshake.
  - Long-latency into an empty FIFO with no competition: pushed at edge N, popped at N+1, `rf_we` high at N+2.
- `rf_we` is high for exactly one cycle per granted write. Back-to-back writes give `rf_we` continuously high.
- Worst-case wait for the queue head under continuous `p_valid`: `STARVE_MAX` cycles denied, granted on the next cycle.
- Reset asserted mid-operation: queued entries are discarded, and `rf_we` drops asynchronously to 0.

## Structure
- Shared package `Common`:
  - `WbReq` struct: `wreg` [4:0], `wdata` [31:0].
  - `WbSrc` enum: `SrcPipe`=0, `SrcLong`=1.
- Sub-module `wb_fifo`:
  - Parameterized synchronous FIFO with full/empty flags.
  - Exposes entry contents and valid bits so the top level can build `pend_mask`.
  - Reused for other queues.
- Top level holds the arbitration logic, `starve_cnt` and the output register.

## Test plan
- Reset, then `p_valid`=1, `p_wreg`=5, `p_wdata`=0xDEADBEEF for one cycle -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `rf_src`=0; `rf_we`=0 the cycle after.
- `l_valid` with `l_wreg`=7, `l_wdata`=0x1234, no pipeline traffic -> `pend_mask`=0x80 for one cycle, then `rf_we`=1 with `rf_src`=1, then `pend_mask`=0.
- With `STARVE_MAX`=4, continuous `p_valid`, and one queued entry for x9 -> exactly 4 pipeline grants, then `p_ready`=0 for one cycle and x9 is written, then pipeline grants resume.
- Three `l_valid` requests back-to-back with `FIFO_DEPTH`=2 under continuous `p_valid` -> `l_ready`=0 on the third until a pop; all three retire in order, and no entry is lost or duplicated.
- `p_wreg`=0 and `l_wreg`=0 requests -> both handshakes complete, `rf_we` stays 0, and `pend_mask` stays 0.
- `rst` driven low while the FIFO holds 2 entries and `rf_we`=1 -> outputs go to 0 immediately; after release, `l_ready`=1 and nothing is written.
